// File: rtl/eff_chain_seq.sv
// eff_chain_seq: runs one multi-channel frame through NUM_SLOTS external
// effect slots in index order over a valid-pulse handshake. Disabled slots are
// skipped, silent slots are bypassed after TIMEOUT cycles. Sticky per-slot
// timeout flags and an overrun flag report abnormal traffic.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for vld_i; captures frame and per-frame config
//   S_SCAN  | look at slot idx: issue it, skip it, or emit the frame
//   S_ISSUE | one-cycle strobe of slot_vld_o[idx] with work on slot_data_o
//   S_WAIT  | wait for slot idx to return, or give up after TIMEOUT cycles
module eff_chain_seq #(
   parameter int DATA_WIDTH = 24,
   parameter int NUM_CH     = 2,
   parameter int NUM_SLOTS  = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  en,
   input  logic [NUM_SLOTS-1:0]                  sel,
   input  logic                                  mono,
   input  logic                                  clr_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0]          data_i,
   input  logic                                  vld_i,
   output logic                                  busy_o,
   output logic [NUM_CH*DATA_WIDTH-1:0]          data_o,
   output logic                                  vld_o,
   output logic [NUM_CH*DATA_WIDTH-1:0]          slot_data_o,
   output logic [NUM_SLOTS-1:0]                  slot_vld_o,
   input  logic [NUM_SLOTS*NUM_CH*DATA_WIDTH-1:0] slot_data_i,
   input  logic [NUM_SLOTS-1:0]                  slot_vld_i,
   output logic [NUM_SLOTS-1:0]                  err_o,
   output logic                                  ovr_o
);

   localparam int FW = NUM_CH * DATA_WIDTH;
   localparam int IW = $clog2(NUM_SLOTS + 1);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IW-1:0] IDX_END = IW'(NUM_SLOTS);
   localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [FW-1:0]        work_q, work_d;
   logic [FW-1:0]        data_q, data_d;
   logic                 vld_q, vld_d;
   logic [NUM_SLOTS-1:0] act_q, act_d;
   logic                 mono_q, mono_d;
   logic [NUM_SLOTS-1:0] err_q, err_d;
   logic                 ovr_q, ovr_d;

   logic                 cur_act;
   logic                 cur_vld;
   logic [FW-1:0]        cur_data;
   logic [NUM_SLOTS-1:0] idx_oh;
   logic [FW-1:0]        mono_frame;

   // Select the enable, return valid and return frame of the current slot.
   always_comb begin
      cur_act  = 1'b0;
      cur_vld  = 1'b0;
      cur_data = '0;
      idx_oh   = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (idx_q == IW'(s)) begin
            cur_act   = act_q[s];
            cur_vld   = slot_vld_i[s];
            cur_data  = slot_data_i[s*FW +: FW];
            idx_oh[s] = 1'b1;
         end
      end
   end

   // Work frame with ch0 replicated onto every channel.
   always_comb begin
      mono_frame = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         mono_frame[c*DATA_WIDTH +: DATA_WIDTH] = work_q[DATA_WIDTH-1:0];
      end
   end

   // Next-state and datapath decisions for the slot walk.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      data_d  = data_q;
      vld_d   = 1'b0;
      act_d   = act_q;
      mono_d  = mono_q;
      err_d   = clr_i ? '0 : err_q;
      ovr_d   = clr_i ? 1'b0 : ovr_q;

      // Frames arriving mid-walk are dropped; set after clear so set wins.
      if (vld_i && (state_q != S_IDLE)) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (vld_i) begin
               work_d  = data_i;
               act_d   = sel & {NUM_SLOTS{en}};
               mono_d  = mono;
               idx_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (idx_q == IDX_END) begin
               data_d  = mono_q ? mono_frame : work_q;
               vld_d   = 1'b1;
               state_d = S_IDLE;
            end else if (cur_act) begin
               state_d = S_ISSUE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cur_vld) begin
               work_d  = cur_data;
               idx_d   = idx_q + IW'(1);
               state_d = S_SCAN;
            end else if (cnt_q == CNT_TO) begin
               err_d   = err_d | idx_oh;
               idx_d   = idx_q + IW'(1);
               state_d = S_SCAN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         work_q  <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         act_q   <= '0;
         mono_q  <= 1'b0;
         err_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         act_q   <= act_d;
         mono_q  <= mono_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

   // Issue strobe decoded purely from registers so slots see a clean pulse.
   always_comb begin
      slot_vld_o = '0;
      if (state_q == S_ISSUE) begin
         slot_vld_o = idx_oh;
      end
   end

   assign busy_o      = (state_q != S_IDLE);
   assign data_o      = data_q;
   assign vld_o       = vld_q;
   assign slot_data_o = work_q;
   assign err_o       = err_q;
   assign ovr_o       = ovr_q;

endmodule

// File: tb/tb_eff_chain_seq.sv
// Bench for eff_chain_seq: behavioural slot responder, scoreboard of expected
// output frames and their arrival cycle, directed scenarios.
module tb_eff_chain_seq;

   localparam int DW = 24;
   localparam int NC = 2;
   localparam int NS = 4;
   localparam int TO = 8;
   localparam int FW = DW * NC;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             mono = 1'b0;
   logic             clr_i = 1'b0;
   logic             vld_i = 1'b0;
   logic [NS-1:0]    sel = '0;
   logic [FW-1:0]    data_i = '0;
   logic             busy_o, vld_o, ovr_o;
   logic [FW-1:0]    data_o, slot_data_o;
   logic [NS-1:0]    slot_vld_o, err_o;
   logic [NS-1:0]    slot_vld_i = '0;
   logic [NS*FW-1:0] slot_data_i = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int vld_cnt = 0;

   typedef struct {
      logic [FW-1:0] d;
      int            t;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mx;
   logic [NS-1:0] slot_log[$];

   int            lat = 3;
   logic [NS-1:0] resp_en = '1;
   bit            pend = 1'b0;
   int            rcnt = 0;
   int            ps = 0;
   logic [FW-1:0] pdata = '0;

   eff_chain_seq #(
      .DATA_WIDTH(DW), .NUM_CH(NC), .NUM_SLOTS(NS), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .sel(sel), .mono(mono), .clr_i(clr_i),
      .data_i(data_i), .vld_i(vld_i), .busy_o(busy_o), .data_o(data_o),
      .vld_o(vld_o), .slot_data_o(slot_data_o), .slot_vld_o(slot_vld_o),
      .slot_data_i(slot_data_i), .slot_vld_i(slot_vld_i), .err_o(err_o),
      .ovr_o(ovr_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [FW-1:0] inc(input logic [FW-1:0] f);
      logic [FW-1:0] r;
      for (int c = 0; c < NC; c++) r[c*DW +: DW] = f[c*DW +: DW] + DW'(1);
      return r;
   endfunction

   // Slot model: returns the issued frame +1 per channel, lat cycles after issue.
   always @(negedge clk) begin
      slot_vld_i = '0;
      if (pend) begin
         rcnt--;
         if (rcnt == 0) begin
            slot_vld_i[ps] = 1'b1;
            slot_data_i[ps*FW +: FW] = pdata;
            pend = 1'b0;
         end
      end
      for (int s = 0; s < NS; s++) begin
         if (slot_vld_o[s] && resp_en[s]) begin
            pend  = 1'b1;
            rcnt  = lat;
            ps    = s;
            pdata = inc(slot_data_o);
         end
      end
   end

   // Output monitor: pop expected frame and arrival cycle on every vld_o.
   always @(negedge clk) begin
      if (|slot_vld_o) slot_log.push_back(slot_vld_o);
      if (vld_o) begin
         vld_cnt++;
         if (exp_q.size() == 0) begin
            check("vld_o_unexpected", {63'd0, vld_o}, 64'd0);
         end else begin
            mx = exp_q.pop_front();
            check("frame_data", {16'd0, data_o}, {16'd0, mx.d});
            check("frame_latency", cyc, mx.t);
         end
      end
   end

   // Drive one frame and push the reference result and arrival cycle.
   task automatic send_frame(input logic [FW-1:0] d, input logic e,
                             input logic [NS-1:0] s, input logic m);
      exp_t          x;
      int            t;
      logic [DW-1:0] ch0;
      t   = NS + 2;
      x.d = d;
      for (int i = 0; i < NS; i++) begin
         if (e && s[i]) begin
            if (resp_en[i]) begin
               x.d = inc(x.d);
               t   = t + 1 + lat;
            end else begin
               t = t + 1 + TO;
            end
         end
      end
      if (m) begin
         ch0 = x.d[DW-1:0];
         for (int c = 0; c < NC; c++) x.d[c*DW +: DW] = ch0;
      end
      @(negedge clk);
      data_i = d; en = e; sel = s; mono = m; vld_i = 1'b1;
      x.t = cyc + t;
      exp_q.push_back(x);
      @(negedge clk);
      vld_i = 1'b0;
   endtask

   task automatic pulse_raw(input logic [FW-1:0] d);
      @(negedge clk);
      data_i = d; vld_i = 1'b1;
      @(negedge clk);
      vld_i = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_i = 1'b1;
      @(negedge clk);
      clr_i = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("wait_budget", exp_q.size(), 0);
      @(negedge clk);
   endtask

   int snap;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy_o, 0);
      check("rst_data", data_o, 0);
      check("rst_vld", vld_o, 0);
      check("rst_err", err_o, 0);
      check("rst_ovr", ovr_o, 0);
      check("rst_slot_vld", slot_vld_o, 0);

      // bypass
      slot_log.delete();
      send_frame({24'h000123, 24'h7FFFFF}, 1'b0, 4'hF, 1'b0);
      wait_done();
      check("byp_slot_vld", slot_log.size(), 0);
      check("byp_data", data_o, {24'h000123, 24'h7FFFFF});

      // all slots enabled, latency 3
      lat = 3; resp_en = '1;
      slot_log.delete();
      send_frame({24'h000020, 24'h000010}, 1'b1, 4'hF, 1'b0);
      wait_done();
      check("all_ch0", data_o[DW-1:0], 24'h000014);
      check("all_issue_cnt", slot_log.size(), 4);
      for (int i = 0; i < 4 && i < slot_log.size(); i++)
         check("all_issue_order", slot_log[i], 4'b0001 << i);

      // timeout on slot 1
      resp_en = 4'b1101;
      send_frame({24'h0000AA, 24'h000055}, 1'b1, 4'b0010, 1'b0);
      wait_done();
      check("to_err", err_o, 4'b0010);
      check("to_data", data_o, {24'h0000AA, 24'h000055});
      pulse_clr();
      check("to_clr", err_o, 0);
      send_frame({24'h000001, 24'h000002}, 1'b1, 4'b0010, 1'b0);
      repeat (10) @(negedge clk);
      clr_i = 1'b1;
      @(negedge clk);
      clr_i = 1'b0;
      wait_done();
      check("to_clr_vs_set", err_o, 4'b0010);
      pulse_clr();
      resp_en = '1;

      // overrun while busy and sel change mid-frame
      check("ovr_pre", ovr_o, 0);
      snap = vld_cnt;
      slot_log.delete();
      send_frame({24'h000100, 24'h000200}, 1'b1, 4'b0001, 1'b0);
      @(negedge clk);
      data_i = {24'h0DEAD0, 24'h0BEEF0}; sel = 4'b1000; vld_i = 1'b1;
      @(negedge clk);
      vld_i = 1'b0;
      wait_done();
      check("ovr_set", ovr_o, 1);
      check("ovr_one_vld", vld_cnt - snap, 1);
      check("ovr_old_sel", slot_log.size() > 0 ? slot_log[0] : 4'h0, 4'b0001);
      slot_log.delete();
      send_frame({24'h000300, 24'h000400}, 1'b1, 4'b1000, 1'b0);
      wait_done();
      check("new_sel", slot_log.size() > 0 ? slot_log[0] : 4'h0, 4'b1000);

      // overrun on the final SCAN cycle
      pulse_clr();
      check("ovr_clr", ovr_o, 0);
      send_frame({24'h000007, 24'h000008}, 1'b0, 4'h0, 1'b0);
      repeat (3) @(negedge clk);
      pulse_raw({24'h000009, 24'h00000A});
      wait_done();
      check("ovr_last_scan", ovr_o, 1);
      pulse_clr();

      // mono
      send_frame({24'h111111, 24'hABCDEF}, 1'b0, 4'h0, 1'b1);
      wait_done();
      check("mono_data", data_o, {24'hABCDEF, 24'hABCDEF});
      repeat (5) @(negedge clk);
      check("data_hold", data_o, {24'hABCDEF, 24'hABCDEF});

      // reset during WAIT, slot answers after reset
      lat = 5; resp_en = '1;
      snap = vld_cnt;
      @(negedge clk);
      data_i = {24'h000555, 24'h000666}; en = 1'b1; sel = 4'b0001; mono = 1'b0; vld_i = 1'b1;
      @(negedge clk);
      vld_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rw_busy_pre", busy_o, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rw_busy", busy_o, 0);
      check("rw_data", data_o, 0);
      check("rw_slot_data", slot_data_o, 0);
      check("rw_slot_vld", slot_vld_o, 0);
      check("rw_err", err_o, 0);
      repeat (10) @(negedge clk);
      check("rw_no_vld", vld_cnt - snap, 0);
      check("rw_busy_late", busy_o, 0);
      lat = 3;
      send_frame({24'h000010, 24'h000020}, 1'b1, 4'b0001, 1'b0);
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
